store_watch: RTL and testbench

//  Test-harness consumer sitting directly downstream of the top-level rv32i pipeline core.

---
 rtl/store_watch_pkg.sv | 16 +
 rtl/sw_log_fifo.sv | 75 +++++++
 rtl/store_watch.sv | 109 ++++++++++
 tb/tb_store_watch.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/store_watch_pkg.sv
// Shared types for the store_watch test-harness consumer.
package store_watch_pkg;

    typedef enum logic [1:0] {
        SW_RUN     = 2'd0,
        SW_PASS    = 2'd1,
        SW_FAIL    = 2'd2,
        SW_TIMEOUT = 2'd3
    } sw_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sw_entry_t;

endpackage

// File: rtl/sw_log_fifo.sv
// Circular store log: keeps the most recent DEPTH entries, overwriting the oldest when full.
// Head entry is presented first-word fall-through; dout reads as zero when empty.
module sw_log_fifo
    import store_watch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  sw_entry_t din,
    output sw_entry_t dout,
    output logic      valid,
    output logic      overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sw_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            empty, full, pop_eff;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop_eff = pop && !empty;

    // A pop alongside a push keeps occupancy, so only a push into a full log without a pop loses data.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
            if (pop_eff) begin
                head_d = head_q + 1'b1;
            end else if (full) begin
                head_d = head_q + 1'b1;
                ovf_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_eff) begin
            head_d = head_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= din;
    end

    assign valid    = !empty;
    assign dout     = empty ? '0 : mem_q[head_q];
    assign overflow = ovf_q;

endmodule

// File: rtl/store_watch.sv
// Watches the core's data-memory write port, counts stores and decides PASS/FAIL/TIMEOUT.
// Define STORE_WATCH_LOG_EN to build the post-mortem store log (rd_* and overflow).
module store_watch
    import store_watch_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter int          TIMEOUT_CYCLES = 500,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ControlW,
    input  logic [31:0] DataAdr,
    input  logic [31:0] Data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [15:0] store_cnt,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        overflow
);
    sw_state_t   state_q;
    logic [31:0] cycle_q;
    logic [15:0] store_q;
    logic        done_q, pass_q, fail_q, timeout_q;
    logic        store_acc, verdict_hit;

    // if() routes an X/Z strobe to the else branch, so an unknown ControlW never counts as a store.
    always_comb begin
        store_acc = 1'b0;
        if (ControlW) begin
            if (state_q == SW_RUN) store_acc = 1'b1;
        end
        verdict_hit = store_acc && (DataAdr == PASS_ADDR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SW_RUN;
            cycle_q   <= '0;
            store_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (state_q == SW_RUN) begin
            if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
            if (store_acc && store_q != '1) store_q <= store_q + 1'b1;
            if (verdict_hit) begin
                done_q <= 1'b1;
                if (Data == PASS_DATA) begin
                    state_q <= SW_PASS;
                    pass_q  <= 1'b1;
                end else begin
                    state_q <= SW_FAIL;
                    fail_q  <= 1'b1;
                end
            end else if (cycle_q == 32'(TIMEOUT_CYCLES - 1)) begin
                state_q   <= SW_TIMEOUT;
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_q;
    assign store_cnt = store_q;

`ifdef STORE_WATCH_LOG_EN
    sw_entry_t log_in, log_out;

    assign log_in = '{addr: DataAdr, data: Data};

    sw_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
        .clk      (clk),
        .reset    (reset),
        .push     (store_acc),
        .pop      (rd_en),
        .din      (log_in),
        .dout     (log_out),
        .valid    (rd_valid),
        .overflow (overflow)
    );

    assign rd_addr = log_out.addr;
    assign rd_data = log_out.data;
`else
    logic unused_rd_en;

    assign unused_rd_en = rd_en;
    assign rd_valid     = 1'b0;
    assign rd_addr      = '0;
    assign rd_data      = '0;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_store_watch.sv
// Directed bench for store_watch; log checks follow STORE_WATCH_LOG_EN like the design.
module tb_store_watch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ControlW = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] Data = '0;
    logic        rd_en = 1'b0;
    logic        done, pass, fail, timeout, rd_valid, overflow;
    logic [1:0]  state;
    logic [31:0] cycle_cnt, rd_addr, rd_data;
    logic [15:0] store_cnt;

    int errs = 0;
    int checks = 0;

    store_watch #(
        .PASS_ADDR(32'd100), .PASS_DATA(32'd25), .TIMEOUT_CYCLES(20), .LOG_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .ControlW(ControlW), .DataAdr(DataAdr), .Data(Data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .state(state),
        .cycle_cnt(cycle_cnt), .store_cnt(store_cnt), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        ControlW = 1'b1; DataAdr = a; Data = d;
        tick();
        ControlW = 1'b0; DataAdr = '0; Data = '0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] a, input logic [31:0] d);
`ifdef STORE_WATCH_LOG_EN
        chk({tag, "_vld"}, rd_valid, 1);
        chk({tag, "_addr"}, rd_addr, a);
        chk({tag, "_data"}, rd_data, d);
`else
        chk({tag, "_vld"}, rd_valid, 0);
        chk({tag, "_addr"}, rd_addr, 0);
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic log_empty_chk(input string tag, input logic exp_ovf);
        chk({tag, "_vld"}, rd_valid, 0);
        chk({tag, "_addr"}, rd_addr, 0);
        chk({tag, "_data"}, rd_data, 0);
`ifdef STORE_WATCH_LOG_EN
        chk({tag, "_ovf"}, overflow, exp_ovf);
`else
        chk({tag, "_ovf"}, overflow, 0);
`endif
    endtask

    initial begin
        // power-on reset state
        #2;
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_st", store_cnt, 0);
        log_empty_chk("rst", 1'b0);
        reset = 1'b0;
        tick();

        // T1: stores then an asynchronous reset pulse between edges
        do_reset();
        store(32'd4, 32'd1); store(32'd8, 32'd2); store(32'd12, 32'd3);
        chk("t1_st3", store_cnt, 3);
        chk("t1_cyc3", cycle_cnt, 3);
        ControlW = 1'bx; DataAdr = 32'd100; Data = 32'd24;
        tick();
        ControlW = 1'b0;
        chk("t1_x_st", store_cnt, 3);
        chk("t1_x_state", state, 0);
        reset = 1'b1;
        #2;
        chk("t1_cyc", cycle_cnt, 0);
        chk("t1_st", store_cnt, 0);
        chk("t1_vld", rd_valid, 0);
        chk("t1_state", state, 0);
        reset = 1'b0;

        // T2: pass verdict, then post-verdict store ignored, then log readout
        tick();
        do_reset();
        store(32'd4, 32'd7); store(32'd8, 32'd9);
        chk("t2_prepass", pass, 0);
        store(32'd100, 32'd25);
        chk("t2_pass", pass, 1);
        chk("t2_done", done, 1);
        chk("t2_fail", fail, 0);
        chk("t2_state", state, 1);
        chk("t2_st", store_cnt, 3);
        chk("t2_cyc", cycle_cnt, 3);
        store(32'd4, 32'd4);
        tick(3);
        chk("t2_st_frz", store_cnt, 3);
        chk("t2_cyc_frz", cycle_cnt, 3);
        pop_chk("t2_p0", 32'd4, 32'd7);
        pop_chk("t2_p1", 32'd8, 32'd9);
        pop_chk("t2_p2", 32'd100, 32'd25);
        log_empty_chk("t2_end", 1'b0);

        // T3: fail verdict is terminal
        do_reset();
        store(32'd100, 32'd24);
        chk("t3_fail", fail, 1);
        chk("t3_pass", pass, 0);
        chk("t3_state", state, 2);
        store(32'd100, 32'd25);
        chk("t3_fail2", fail, 1);
        chk("t3_pass2", pass, 0);
        chk("t3_st", store_cnt, 1);

        // T4: timeout after 20 RUN cycles
        do_reset();
        tick(19);
        chk("t4_pre_to", timeout, 0);
        chk("t4_cyc19", cycle_cnt, 19);
        tick();
        chk("t4_to", timeout, 1);
        chk("t4_done", done, 1);
        chk("t4_state", state, 3);
        tick(5);
        chk("t4_cyc_frz", cycle_cnt, 20);
        store(32'd100, 32'd25);
        chk("t4_nopass", pass, 0);

        // T5: verdict store on the timeout cycle wins
        do_reset();
        tick(19);
        store(32'd100, 32'd25);
        chk("t5_pass", pass, 1);
        chk("t5_to", timeout, 0);
        chk("t5_cyc", cycle_cnt, 20);
        tick(3);
        chk("t5_to2", timeout, 0);
        chk("t5_state", state, 1);

        // T6: 10 stores into an 8-entry log overwrite the two oldest
        do_reset();
        for (int i = 0; i < 10; i++) store(32'(i * 4), 32'(i));
        chk("t6_st", store_cnt, 10);
`ifdef STORE_WATCH_LOG_EN
        chk("t6_ovf", overflow, 1);
`else
        chk("t6_ovf", overflow, 0);
`endif
        for (int i = 2; i < 10; i++) pop_chk($sformatf("t6_p%0d", i), 32'(i * 4), 32'(i));
        log_empty_chk("t6_end", 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
